march_bist_controller: RTL
==========================

Name: march_bist_controller

Overview:
Sequencer that runs a March C- test on the 256x4 single-port SRAM and replaces the free-running address counter and fixed Done counter.
- Drives SRAM address, write enable and write data, one operation per cycle.
- Checks read data through a latency-matched pipeline and reports pass/fail, first-failure location and error count.
- Sits between the top-level BIST wrapper and the SRAM instance.

Parameters:
ADDR_W, 8, SRAM address width; DEPTH = 2**ADDR_W.
DATA_W, 4, SRAM word width.
RD_LAT, 1, cycles from read address presented to mem_dout valid; legal values 1..2.

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request to run the test; sampled only in IDLE or DONE.
mem_addr  out  ADDR_W  SRAM address.
mem_we  out  1  SRAM write enable; 0 means read.
mem_din  out  DATA_W  SRAM write data.
mem_dout  in  DATA_W  SRAM read data.
busy  out  1  high from the cycle after start is accepted until done rises.
done  out  1  level; held high until the next accepted start or Reset.
fail  out  1  sticky; set on the first read mismatch.
fail_addr  out  ADDR_W  address of the first mismatch.
fail_elem  out  3  March element index (0..5) of the first mismatch.
err_count  out  8  total mismatches, saturating at 255.

Behaviour:
- Reset (async): state=IDLE; mem_addr=0, mem_we=0, mem_din=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, err_count=0; read pipeline valid bits cleared.
- States: IDLE -> RUN on start; RUN -> DRAIN after the last op of M5; DRAIN -> DONE after RD_LAT cycles; DONE -> RUN on start.
- Accepting start clears fail, fail_addr, fail_elem, err_count and done; loads elem=0, op=0, addr=0.
- Background: "0" = {DATA_W{1'b0}}, "1" = {DATA_W{1'b1}}.
- Elements:
  - M0: up(w0)
  - M1: up(r0,w1)
  - M2: up(r1,w0)
  - M3: down(r0,w1)
  - M4: down(r1,w0)
  - M5: down(r0)
- "up" sweeps 0..DEPTH-1; "down" sweeps DEPTH-1..0.
- Op order within an address: each op occupies one cycle; all ops for one address complete before the address steps.
- Element entry: address loads 0 for up elements and DEPTH-1 for down elements. No idle cycle between elements.
- Total RUN cycles: 10*DEPTH, i.e. 2560 for the default configuration.
- Writes: mem_we=1 and mem_din=background for that op. Reads: mem_we=0, mem_din=0.
- Read pipeline: each read pushes {valid, expected, addr, elem} into a RD_LAT-deep shift register. When the entry emerges, mem_dout is compared in that cycle; the result is registered.
- On mismatch: err_count increments with saturation at 255. If fail=0, fail is set and fail_addr/fail_elem are captured in the same edge.
- DRAIN: mem_we=0 and mem_addr is held; the pipeline flushes.
- done rises 10*DEPTH+RD_LAT+1 edges after the start-sampling edge, with busy falling on the same edge.
- Outputs fail, fail_addr, fail_elem and err_count are final when done=1.
- start while busy=1 is ignored.
- Reset mid-run aborts immediately; mem_we=0 asynchronously, so no partial write follows.
- Down-sweep terminates on addr==0 and must not rely on wrap-around. An up-sweep ending at DEPTH-1 must not emit an extra op at address 0.

Decomposition:
- Shared package march_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - element index constants M0..M5
  - per-element constant tables: direction, op count (1 or 2), read-expected background, write background
  - BG0/BG1 constants
- Sub-module march_read_checker owns:
  - RD_LAT-deep expected/addr/elem/valid pipeline
  - comparator
  - sticky fail, first-fail capture, saturating err_count
- Sequencer FSM plus address/op counters stay in march_bist_controller.

Test Plan:
- Fault-free behavioural SRAM (RD_LAT=1), pulse start at cycle 5 -> done rises 2562 edges later, busy high for exactly 2561 cycles, fail=0, err_count=0.
- Bit 0 stuck-at-1 at address 0x5A -> fail=1, fail_addr=0x5A, fail_elem=1, err_count=3 (r0 in M1, M3, M5).
- Every cell stuck at 4'h0 -> fail=1, fail_addr=0x00, fail_elem=2, err_count=255 (saturated from 512 mismatches).
- Address trace check -> M0 writes 0x00..0xFF ascending; M3's first op is a read at 0xFF; M5's last op is a read at 0x00; each address appears exactly once per element.
- Reset asserted at cycle 1000 of RUN -> all outputs 0 in the same cycle, mem_we=0; a new start then completes a clean run with fail=0.
- start pulsed mid-RUN -> ignored, done timing unchanged. start pulsed in DONE -> done drops next edge, results cleared, run repeats.

Source files
------------

// File: rtl/march_pkg.sv
// Shared types and March C- element tables for the BIST sequencer and read checker.
package march_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // March element indices
  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // Background selectors; replicated to the word width by the user
  localparam logic BG0 = 1'b0;
  localparam logic BG1 = 1'b1;

  // Per-element tables, bit n describes element Mn
  localparam logic [5:0] ELEM_DOWN    = 6'b111000;  // M3..M5 sweep downwards
  localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;  // M1..M4 are (read, write)
  localparam logic [5:0] ELEM_RD_BG   = 6'b010100;  // M2, M4 read back "1"
  localparam logic [5:0] ELEM_WR_BG   = 6'b001010;  // M1, M3 write "1"

  function automatic logic elem_down(input logic [2:0] e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return ELEM_TWO_OPS[e];
  endfunction

  function automatic logic elem_rd_bg(input logic [2:0] e);
    return ELEM_RD_BG[e] ? BG1 : BG0;
  endfunction

  function automatic logic elem_wr_bg(input logic [2:0] e);
    return ELEM_WR_BG[e] ? BG1 : BG0;
  endfunction

endpackage

// File: rtl/march_bist_controller_read_checker.sv
// Latency-matched read checker: delays expected data alongside the SRAM read
// and accumulates sticky fail, first-failure location and saturating error count.
module march_read_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [2:0]        in_elem,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        err_count
);

  logic [RD_LAT-1:0] p_valid;
  logic [DATA_W-1:0] p_exp  [RD_LAT];
  logic [ADDR_W-1:0] p_addr [RD_LAT];
  logic [2:0]        p_elem [RD_LAT];
  logic              mismatch;

  // Shift read descriptors so the tail lines up with mem_dout
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      p_valid <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        p_exp[i]  <= '0;
        p_addr[i] <= '0;
        p_elem[i] <= '0;
      end
    end else begin
      p_valid[0] <= in_valid & ~clear;
      p_exp[0]   <= in_exp;
      p_addr[0]  <= in_addr;
      p_elem[0]  <= in_elem;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        p_valid[i] <= p_valid[i-1] & ~clear;
        p_exp[i]   <= p_exp[i-1];
        p_addr[i]  <= p_addr[i-1];
        p_elem[i]  <= p_elem[i-1];
      end
    end
  end

  // Compare the emerging read against the returned SRAM word
  always_comb begin
    mismatch = p_valid[RD_LAT-1] && (mem_dout != p_exp[RD_LAT-1]);
  end

  // Register results: sticky fail with first-failure capture, saturating count
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      err_count <= '0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + 8'd1;
      if (!fail) begin
        fail      <= 1'b1;
        fail_addr <= p_addr[RD_LAT-1];
        fail_elem <= p_elem[RD_LAT-1];
      end
    end
  end

endmodule

// File: rtl/march_bist_controller.sv
// March C- BIST sequencer: walks the six elements over the SRAM, one operation
// per cycle, and hands each read to the latency-matched checker.
module march_bist_controller
  import march_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [7:0]        err_count
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT);

  state_t            state;
  logic [2:0]        elem;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        drain_cnt;
  logic              iss_rd;
  logic [DATA_W-1:0] iss_exp;
  logic [2:0]        iss_elem;
  logic              clear;
  logic              is_down;
  logic              is_read;
  logic              last_op;
  logic              last_addr;
  logic [2:0]        next_elem;

  function automatic logic [DATA_W-1:0] bg(input logic b);
    return {DATA_W{b}};
  endfunction

  // Decode the current (element, op, address) position
  always_comb begin
    is_down   = elem_down(elem);
    is_read   = (elem != M0) && !op;
    last_op   = elem_two_ops(elem) ? op : 1'b1;
    // Sweep end is an explicit compare so the down-sweep never relies on wrap
    last_addr = is_down ? (addr == '0) : (addr == '1);
    next_elem = elem + 3'd1;
    clear     = start && ((state == IDLE) || (state == DONE));
  end

  // Sequencer FSM with registered SRAM-side outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      elem      <= M0;
      op        <= 1'b0;
      addr      <= '0;
      drain_cnt <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      iss_rd    <= 1'b0;
      iss_exp   <= '0;
      iss_elem  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            elem  <= M0;
            op    <= 1'b0;
            addr  <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          busy     <= 1'b1;
          mem_addr <= addr;
          mem_we   <= !is_read;
          mem_din  <= is_read ? '0 : bg(elem_wr_bg(elem));
          iss_rd   <= is_read;
          iss_exp  <= is_read ? bg(elem_rd_bg(elem)) : '0;
          iss_elem <= elem;
          if (!last_op) begin
            op <= 1'b1;
          end else begin
            op <= 1'b0;
            if (!last_addr) begin
              addr <= is_down ? addr - 1'b1 : addr + 1'b1;
            end else if (elem == M5) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              elem <= next_elem;
              addr <= elem_down(next_elem) ? '1 : '0;
            end
          end
        end
        DRAIN: begin
          mem_we  <= 1'b0;
          mem_din <= '0;
          iss_rd  <= 1'b0;
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  march_read_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_checker (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (clear),
    .in_valid (iss_rd),
    .in_exp   (iss_exp),
    .in_addr  (mem_addr),
    .in_elem  (iss_elem),
    .mem_dout (mem_dout),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .err_count(err_count)
  );

endmodule
